ecc_serial_port: RTL and testbench

ECC_SERIAL_PORT -- requirements
Module: ecc_serial_port

---
 rtl/ecc_serial_port.sv | 177 +++++++++++++++++
 tb/tb_ecc_serial_port.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_serial_port.sv
// Serial front end for an ECC core: deserializes a mode+word frame and serializes result words MSB first.
// Define ECC_SP_FRAME_CHECK_EN to abort frames on an i_valid gap (o_frame_err) instead of stalling.
`timescale 1ns/1ps
module ecc_serial_port #(
  parameter int BIT     = 32,
  parameter int NCH_IN  = 6,
  parameter int NCH_OUT = 2,
  parameter int MODE_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [NCH_IN-1:0]        i_din,
  output logic [MODE_W-1:0]        o_mode,
  output logic [NCH_IN*BIT-1:0]    o_words,
  output logic                     o_start,
  output logic                     o_frame_err,
  input  logic                     i_res_valid,
  input  logic [NCH_OUT*BIT-1:0]   i_res,
  output logic                     o_res_ready,
  output logic                     o_valid,
  output logic [NCH_OUT-1:0]       o_dout
);

  localparam int CW = $clog2(BIT);

  typedef enum logic [1:0] {R_IDLE, R_MODE, R_DATA} rx_state_t;

  rx_state_t                   state, state_n;
  logic [CW-1:0]               cnt, cnt_n;
  logic                        last_bit;
  logic [MODE_W-1:0]           mode_sr;
  // Only BIT-1 bits per channel are stored; the final bit goes straight from i_din to o_words.
  logic [NCH_IN*(BIT-1)-1:0]   data_sr, data_sr_nx;
  logic [NCH_IN*BIT-1:0]       data_nx;

  logic [NCH_OUT*BIT-1:0]      tx_sr;
  logic                        busy;
  logic [CW-1:0]               tx_cnt;

  always_comb begin
    data_nx    = '0;
    data_sr_nx = '0;
    for (int unsigned c = 0; c < NCH_IN; c++) begin
      data_nx[c*BIT +: BIT]            = {data_sr[c*(BIT-1) +: BIT-1], i_din[c]};
      data_sr_nx[c*(BIT-1) +: BIT-1]   = data_nx[c*BIT +: BIT-1];
    end
  end

`ifdef ECC_SP_FRAME_CHECK_EN
  logic abort;
  assign abort = (state != R_IDLE) && !i_valid;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= R_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_bit = 1'b0;
    case (state)
      R_IDLE: begin
        if (i_valid) begin
          if (MODE_W == 1) begin
            state_n = R_DATA;
            cnt_n   = '0;
          end else begin
            state_n = R_MODE;
            cnt_n   = CW'(1);
          end
        end
      end
      R_MODE: begin
        if (i_valid) begin
          if (cnt == CW'(MODE_W-1)) begin
            state_n = R_DATA;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      R_DATA: begin
        if (i_valid) begin
          if (cnt == CW'(BIT-1)) begin
            state_n  = R_IDLE;
            cnt_n    = '0;
            last_bit = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_n = R_IDLE;
        cnt_n   = '0;
      end
    endcase
`ifdef ECC_SP_FRAME_CHECK_EN
    if (abort) begin
      state_n = R_IDLE;
      cnt_n   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_sr <= '0;
      data_sr <= '0;
      o_mode  <= '0;
      o_words <= '0;
      o_start <= 1'b0;
    end else begin
      o_start <= last_bit;
      if ((state == R_IDLE || state == R_MODE) && i_valid)
        mode_sr <= MODE_W'({mode_sr, i_din[0]});
      if (state == R_DATA && i_valid)
        data_sr <= data_sr_nx;
      if (last_bit) begin
        o_mode  <= mode_sr;
        o_words <= data_nx;
      end
    end
  end

`ifdef ECC_SP_FRAME_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_frame_err <= 1'b0;
    else      o_frame_err <= abort;
  end
`else
  assign o_frame_err = 1'b0;
`endif

  // Flat left shift: bits leaking across channel boundaries never reach a channel MSB in time to be seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr  <= '0;
      busy   <= 1'b0;
      tx_cnt <= '0;
    end else if (!busy) begin
      if (i_res_valid) begin
        tx_sr  <= i_res;
        busy   <= 1'b1;
        tx_cnt <= '0;
      end
    end else begin
      tx_sr  <= tx_sr << 1;
      tx_cnt <= tx_cnt + CW'(1);
      if (tx_cnt == CW'(BIT-1)) begin
        busy   <= 1'b0;
        tx_cnt <= '0;
      end
    end
  end

  assign o_res_ready = !busy;
  assign o_valid     = busy;

  always_comb begin
    o_dout = '0;
    if (busy) begin
      for (int unsigned c = 0; c < NCH_OUT; c++)
        o_dout[c] = tx_sr[c*BIT + BIT-1];
    end
  end

endmodule

// File: tb/tb_ecc_serial_port.sv
// Directed self-checking bench for ecc_serial_port: default build plus a BIT=8 / 2-in / 1-out instance.
`timescale 1ns/1ps
module tb_ecc_serial_port;
  localparam int BIT = 32;
  localparam int NI  = 6;
  localparam int NO  = 2;
  localparam int MW  = 2;

  logic clk, rst;
  logic i_valid;
  logic [NI-1:0] i_din;
  logic [MW-1:0] o_mode;
  logic [NI*BIT-1:0] o_words;
  logic o_start, o_frame_err;
  logic i_res_valid;
  logic [NO*BIT-1:0] i_res;
  logic o_res_ready, o_valid;
  logic [NO-1:0] o_dout;

  logic s_valid;
  logic [1:0] s_din;
  logic [1:0] s_mode;
  logic [15:0] s_words;
  logic s_start, s_ferr;
  logic s_res_valid;
  logic [7:0] s_res;
  logic s_ready, s_ovalid;
  logic [0:0] s_dout;

  ecc_serial_port #(.BIT(BIT), .NCH_IN(NI), .NCH_OUT(NO), .MODE_W(MW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_din(i_din), .o_mode(o_mode),
    .o_words(o_words), .o_start(o_start), .o_frame_err(o_frame_err),
    .i_res_valid(i_res_valid), .i_res(i_res), .o_res_ready(o_res_ready),
    .o_valid(o_valid), .o_dout(o_dout));

  ecc_serial_port #(.BIT(8), .NCH_IN(2), .NCH_OUT(1), .MODE_W(2)) dut_small (
    .clk(clk), .rst(rst), .i_valid(s_valid), .i_din(s_din), .o_mode(s_mode),
    .o_words(s_words), .o_start(s_start), .o_frame_err(s_ferr),
    .i_res_valid(s_res_valid), .i_res(s_res), .o_res_ready(s_ready),
    .o_valid(s_ovalid), .o_dout(s_dout));

  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  int st_cyc[$];
  logic [NI*BIT-1:0] st_words[$];
  logic [MW-1:0] st_mode[$];
  int fe_cyc[$];

  localparam logic [NI*BIT-1:0] WA = {32'hDEADBEEF, 32'h00000000, 32'hA5A5A5A5,
                                      32'hFFFFFFFF, 32'h12345678, 32'h00000002};
  localparam logic [NI*BIT-1:0] WB = {32'h0F0F0F0F, 32'h80000001, 32'h13579BDF,
                                      32'h00000001, 32'hCAFEF00D, 32'h7FFFFFFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_words.push_back(o_words);
      st_mode.push_back(o_mode);
    end
    if (o_frame_err === 1'b1) fe_cyc.push_back(cyc);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    st_cyc.delete();
    st_words.delete();
    st_mode.delete();
    fe_cyc.delete();
  endtask

  task automatic set_bits(input logic [MW-1:0] mode, input logic [NI*BIT-1:0] w, input int idx);
    i_din = '0;
    if (idx < MW) i_din[0] = mode[MW-1-idx];
    else for (int c = 0; c < NI; c++) i_din[c] = w[c*BIT + BIT-1-(idx-MW)];
  endtask

  task automatic drive_frame(input logic [MW-1:0] mode, input logic [NI*BIT-1:0] w,
                             input int gap_at, input int gap_len);
    for (int idx = 0; idx < MW+BIT; idx++) begin
      if (idx == gap_at) begin
        i_valid = 1'b0;
        i_din = '1;
        repeat (gap_len) tick;
      end
      i_valid = 1'b1;
      set_bits(mode, w, idx);
      tick;
    end
    i_valid = 1'b0;
    i_din = '0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    i_valid = 1'b0; i_din = '0; i_res_valid = 1'b0; i_res = '0;
    s_valid = 1'b0; s_din = '0; s_res_valid = 1'b0; s_res = '0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    i_valid = 1'b0; i_din = '0; i_res_valid = 1'b0; i_res = '0;
    s_valid = 1'b0; s_din = '0; s_res_valid = 1'b0; s_res = '0;
    repeat (3) tick;
    if ({o_start, o_frame_err, o_valid, o_dout, o_res_ready} !== 5'b00001) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=00001", {o_start, o_frame_err, o_valid, o_dout, o_res_ready});
    end
    asserts++;
    if (o_words !== '0 || o_mode !== '0) begin
      fails++; $display("FAIL reset_data words=%0h mode=%0h exp=0", o_words, o_mode);
    end
    asserts++;
    rst = 1'b1;
    repeat (2) tick;
    if (o_res_ready !== 1'b1 || o_start !== 1'b0) begin
      fails++; $display("FAIL reset_release ready=%b start=%b exp=1,0", o_res_ready, o_start);
    end
    asserts++;
  endtask

  task automatic test_frame;
    int t0;
    clear_log();
    t0 = cyc;
    drive_frame(2'b10, WA, -1, 0);
    repeat (3) tick;
    if (st_cyc.size() !== 1) begin
      fails++; $display("FAIL frame_start_count got=%0d exp=1", st_cyc.size());
    end
    asserts++;
    if (st_cyc.size() >= 1) begin
      if (st_cyc[0] !== t0 + MW + BIT) begin
        fails++; $display("FAIL frame_latency got=%0d exp=%0d", st_cyc[0] - t0 + 1, MW + BIT + 1);
      end
      asserts++;
      if (st_mode[0] !== 2'b10) begin
        fails++; $display("FAIL frame_mode got=%0h exp=2", st_mode[0]);
      end
      asserts++;
      if (st_words[0][5*BIT +: BIT] !== 32'hDEADBEEF) begin
        fails++; $display("FAIL frame_word5 got=%0h exp=deadbeef", st_words[0][5*BIT +: BIT]);
      end
      asserts++;
      if (st_words[0] !== WA) begin
        fails++; $display("FAIL frame_words got=%0h exp=%0h", st_words[0], WA);
      end
      asserts++;
    end
    if (o_words !== WA || o_mode !== 2'b10) begin
      fails++; $display("FAIL frame_hold got=%0h exp=%0h", o_words, WA);
    end
    asserts++;
    if (fe_cyc.size() !== 0) begin
      fails++; $display("FAIL frame_no_err got=%0d exp=0", fe_cyc.size());
    end
    asserts++;
  endtask

  task automatic test_back_to_back;
    int t0;
    clear_log();
    t0 = cyc;
    drive_frame(2'b10, WA, -1, 0);
    drive_frame(2'b01, WB, -1, 0);
    repeat (3) tick;
    if (st_cyc.size() !== 2) begin
      fails++; $display("FAIL b2b_count got=%0d exp=2", st_cyc.size());
    end
    asserts++;
    if (st_cyc.size() == 2) begin
      if (st_cyc[0] !== t0 + 34 || st_cyc[1] !== t0 + 68) begin
        fails++; $display("FAIL b2b_timing got=%0d,%0d exp=%0d,%0d", st_cyc[0], st_cyc[1], t0 + 34, t0 + 68);
      end
      asserts++;
      if (st_words[0] !== WA || st_mode[0] !== 2'b10) begin
        fails++; $display("FAIL b2b_first got=%0h exp=%0h", st_words[0], WA);
      end
      asserts++;
      if (st_words[1] !== WB || st_mode[1] !== 2'b01) begin
        fails++; $display("FAIL b2b_second got=%0h exp=%0h", st_words[1], WB);
      end
      asserts++;
    end
  endtask

  task automatic test_gap;
    int t0;
    clear_log();
    t0 = cyc;
    drive_frame(2'b11, WB ^ WA, MW + 10, 3);
    repeat (3) tick;
`ifdef ECC_SP_FRAME_CHECK_EN
    if (st_cyc.size() !== 0) begin
      fails++; $display("FAIL gap_no_start got=%0d exp=0", st_cyc.size());
    end
    asserts++;
    if (fe_cyc.size() !== 1) begin
      fails++; $display("FAIL gap_err_count got=%0d exp=1", fe_cyc.size());
    end
    asserts++;
    if (fe_cyc.size() >= 1) begin
      if (fe_cyc[0] !== t0 + 13) begin
        fails++; $display("FAIL gap_err_time got=%0d exp=%0d", fe_cyc[0], t0 + 13);
      end
      asserts++;
    end
    if (o_words !== WB) begin
      fails++; $display("FAIL gap_words_kept got=%0h exp=%0h", o_words, WB);
    end
    asserts++;
`else
    if (st_cyc.size() !== 1) begin
      fails++; $display("FAIL gap_start_count got=%0d exp=1", st_cyc.size());
    end
    asserts++;
    if (st_cyc.size() >= 1) begin
      if (st_cyc[0] !== t0 + 37) begin
        fails++; $display("FAIL gap_latency got=%0d exp=%0d", st_cyc[0], t0 + 37);
      end
      asserts++;
      if (st_words[0] !== (WB ^ WA) || st_mode[0] !== 2'b11) begin
        fails++; $display("FAIL gap_words got=%0h exp=%0h", st_words[0], WB ^ WA);
      end
      asserts++;
    end
    if (fe_cyc.size() !== 0) begin
      fails++; $display("FAIL gap_err_tied got=%0d exp=0", fe_cyc.size());
    end
    asserts++;
`endif
    do_reset();
  endtask

  task automatic test_serial;
    int bad;
    logic e1, e0;
    bad = 0;
    if (o_res_ready !== 1'b1) begin
      fails++; $display("FAIL tx_ready_idle got=%b exp=1", o_res_ready);
    end
    asserts++;
    i_res = {32'h80000001, 32'h0000FFFF};
    i_res_valid = 1'b1;
    tick;
    i_res_valid = 1'b0;
    for (int k = 0; k < BIT; k++) begin
      e1 = (k == 0) || (k == BIT-1);
      e0 = (k >= 16);
      if (o_valid !== 1'b1 || o_dout !== {e1, e0} || o_res_ready !== 1'b0) begin
        bad++;
        $display("FAIL tx_bit%0d valid=%b dout=%b ready=%b exp=1,%b%b,0", k, o_valid, o_dout, o_res_ready, e1, e0);
      end
      if (k == 10) begin
        i_res_valid = 1'b1;
        i_res = '1;
      end else begin
        i_res_valid = 1'b0;
      end
      tick;
    end
    if (bad != 0) fails++;
    asserts++;
    if (o_valid !== 1'b0 || o_dout !== 2'b00 || o_res_ready !== 1'b1) begin
      fails++; $display("FAIL tx_end valid=%b dout=%b ready=%b exp=0,00,1", o_valid, o_dout, o_res_ready);
    end
    asserts++;
    i_res = {32'h00000001, 32'h80000000};
    i_res_valid = 1'b1;
    tick;
    i_res_valid = 1'b0;
    if (o_valid !== 1'b1 || o_dout !== 2'b01) begin
      fails++; $display("FAIL tx_b2b valid=%b dout=%b exp=1,01", o_valid, o_dout);
    end
    asserts++;
    repeat (BIT-1) tick;
    if (o_valid !== 1'b1 || o_dout !== 2'b10) begin
      fails++; $display("FAIL tx_b2b_last valid=%b dout=%b exp=1,10", o_valid, o_dout);
    end
    asserts++;
    tick;
    if (o_valid !== 1'b0) begin
      fails++; $display("FAIL tx_b2b_done valid=%b exp=0", o_valid);
    end
    asserts++;
  endtask

  task automatic test_concurrent;
    clear_log();
    for (int idx = 0; idx < MW+BIT; idx++) begin
      i_valid = 1'b1;
      set_bits(2'b10, WA, idx);
      tick;
    end
    i_valid = 1'b0;
    i_din = '0;
    if (o_start !== 1'b1) begin
      fails++; $display("FAIL conc_start got=%b exp=1", o_start);
    end
    asserts++;
    i_res = {32'hFFFF0000, 32'h00000001};
    i_res_valid = 1'b1;
    tick;
    i_res_valid = 1'b0;
    if (o_valid !== 1'b1 || o_dout !== 2'b10 || o_words !== WA) begin
      fails++; $display("FAIL conc_tx valid=%b dout=%b exp=1,10", o_valid, o_dout);
    end
    asserts++;
    repeat (BIT) tick;
  endtask

  task automatic test_reset_mid;
    int t0;
    clear_log();
    for (int idx = 0; idx < MW + 20; idx++) begin
      i_valid = 1'b1;
      set_bits(2'b01, WA, idx);
      if (idx == 5) begin
        i_res_valid = 1'b1;
        i_res = {32'h80000001, 32'h0000FFFF};
      end else begin
        i_res_valid = 1'b0;
      end
      tick;
    end
    if (o_valid !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre valid=%b exp=1", o_valid);
    end
    asserts++;
    rst = 1'b0;
    i_valid = 1'b0;
    #1;
    if ({o_start, o_frame_err, o_valid, o_dout, o_res_ready} !== 5'b00001 || o_words !== '0 || o_mode !== '0) begin
      fails++; $display("FAIL rstmid_async ctrl=%b words=%0h exp=00001,0",
                        {o_start, o_frame_err, o_valid, o_dout, o_res_ready}, o_words);
    end
    asserts++;
    tick;
    rst = 1'b1;
    repeat (MW + BIT) tick;
    if (st_cyc.size() !== 0) begin
      fails++; $display("FAIL rstmid_no_start got=%0d exp=0", st_cyc.size());
    end
    asserts++;
    t0 = cyc;
    drive_frame(2'b11, WB, -1, 0);
    repeat (2) tick;
    if (st_cyc.size() !== 1) begin
      fails++; $display("FAIL rstmid_next_count got=%0d exp=1", st_cyc.size());
    end
    asserts++;
    if (st_cyc.size() == 1) begin
      if (st_cyc[0] !== t0 + 34 || st_words[0] !== WB || st_mode[0] !== 2'b11) begin
        fails++; $display("FAIL rstmid_next_frame cyc=%0d words=%0h exp=%0d,%0h", st_cyc[0], st_words[0], t0 + 34, WB);
      end
      asserts++;
    end
  endtask

  task automatic test_small;
    logic [7:0] w1, w0, r;
    logic [1:0] m;
    int early;
    w1 = 8'h3C; w0 = 8'hA5; m = 2'b01; r = 8'hB4;
    early = 0;
    for (int idx = 0; idx < 10; idx++) begin
      s_valid = 1'b1;
      if (idx < 2) s_din = {1'b0, m[1-idx]};
      else s_din = {w1[7-(idx-2)], w0[7-(idx-2)]};
      tick;
      if (idx < 9 && s_start !== 1'b0) early++;
    end
    s_valid = 1'b0;
    s_din = '0;
    if (early != 0) begin
      fails++; $display("FAIL small_early got=%0d exp=0", early);
    end
    asserts++;
    if (s_start !== 1'b1 || s_mode !== 2'b01 || s_words !== 16'h3CA5) begin
      fails++; $display("FAIL small_frame start=%b mode=%0h words=%0h exp=1,1,3ca5", s_start, s_mode, s_words);
    end
    asserts++;
    tick;
    if (s_start !== 1'b0) begin
      fails++; $display("FAIL small_pulse got=%b exp=0", s_start);
    end
    asserts++;
    s_res = r;
    s_res_valid = 1'b1;
    tick;
    s_res_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (s_ovalid !== 1'b1 || s_dout[0] !== r[7-k]) begin
        fails++; $display("FAIL small_tx%0d valid=%b dout=%b exp=1,%b", k, s_ovalid, s_dout[0], r[7-k]);
      end
      asserts++;
      tick;
    end
    if (s_ovalid !== 1'b0 || s_ready !== 1'b1) begin
      fails++; $display("FAIL small_tx_end valid=%b ready=%b exp=0,1", s_ovalid, s_ready);
    end
    asserts++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_gap();
    test_serial();
    test_concurrent();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
